sar_adc_multi: RTL and testbench

- Parametrised successive-approximation ADC. Replaces the single-channel, fixed 7-bit paddle ADC.
- Drives a 1-bit PWM DAC (DACout, RC-filtered off-chip) into the external comparator and reads back gtRef.
- Scans CHANNELS analog inputs through an external mux selected by ChanSel.
- Supports single-shot scans and continuous scanning.

---
 rtl/sar_adc_multi_pkg.sv | 19 +
 rtl/sar_adc_multi_pwm_dac.sv | 23 ++
 rtl/sar_adc_multi.sv | 131 +++++++++++++
 tb/tb_sar_adc_multi.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sar_adc_multi_pkg.sv
// sar_adc_multi_pkg: shared state encoding and sizing helpers for the multi-channel SAR ADC.
package sar_adc_multi_pkg;
  typedef enum logic [2:0] {IDLE, MUX_SETTLE, TRIAL, DECIDE, DONE} state_e;

  localparam int DEF_WIDTH          = 7;
  localparam int DEF_CHANNELS       = 2;
  localparam int DEF_SETTLE_PERIODS = 2;
  localparam int DEF_MUX_WAIT       = 4;
  localparam int PWM_PERIOD         = 1 << DEF_WIDTH;
  localparam int TRIAL_CLKS         = DEF_SETTLE_PERIODS * PWM_PERIOD;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int trial_clks(input int width, input int settle_periods);
    return settle_periods * (1 << width);
  endfunction
endpackage

// File: rtl/sar_adc_multi_pwm_dac.sv
// pwm_dac: free-running PWM counter and duty compare; counter parks at 0 while disabled.
module pwm_dac
  import sar_adc_multi_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty,
  output logic             DACout
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb cnt_d = enable ? cnt_q + WIDTH'(1) : '0;

  always_ff @(posedge CLK) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign DACout = enable && (cnt_q < duty);
endmodule

// File: rtl/sar_adc_multi.sv
// sar_adc_multi: multi-channel SAR ADC sequencer driving a PWM DAC into an external comparator.
// state      | meaning
// IDLE       | waiting for Start or Continuous
// MUX_SETTLE | mux switched, DAC held low for MUX_WAIT clocks
// TRIAL      | PWM drives the trial code for SETTLE_PERIODS full periods
// DECIDE     | keep or drop the trial bit from the synchronised comparator
// DONE       | publish the channel result and advance the channel
module sar_adc_multi
  import sar_adc_multi_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int CHANNELS       = DEF_CHANNELS,
  parameter int SETTLE_PERIODS = DEF_SETTLE_PERIODS,
  parameter int MUX_WAIT       = DEF_MUX_WAIT
) (
  input  logic                              CLK,
  input  logic                              Reset,
  input  logic                              gtRef,
  input  logic                              Start,
  input  logic                              Continuous,
  output logic [CHANNELS*WIDTH-1:0]         ADCout,
  output logic                              ADCsampled,
  output logic [clog2_min1(CHANNELS)-1:0]   SampledChan,
  output logic [clog2_min1(CHANNELS)-1:0]   ChanSel,
  output logic                              DACout,
  output logic                              Busy
);
  localparam int CW        = clog2_min1(CHANNELS);
  localparam int BW        = clog2_min1(WIDTH);
  localparam int TRIAL_LEN = trial_clks(WIDTH, SETTLE_PERIODS);
  localparam int TMR_W     = $clog2(((TRIAL_LEN > MUX_WAIT) ? TRIAL_LEN : MUX_WAIT) + 1);
  localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);

  state_e                    state_q, state_d;
  logic [TMR_W-1:0]          tmr_q, tmr_d;
  logic [CW-1:0]             chan_q, chan_d, samp_chan_q, samp_chan_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [WIDTH-1:0]          result_q, result_d, trial;
  logic [CHANNELS*WIDTH-1:0] adc_q, adc_d;
  logic                      sampled_q, sampled_d;
  logic [1:0]                sync_q, sync_d;
  logic                      pwm_en, busy;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      chan_q      <= '0;
      samp_chan_q <= '0;
      bit_q       <= '0;
      result_q    <= '0;
      adc_q       <= '0;
      sampled_q   <= 1'b0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      chan_q      <= chan_d;
      samp_chan_q <= samp_chan_d;
      bit_q       <= bit_d;
      result_q    <= result_d;
      adc_q       <= adc_d;
      sampled_q   <= sampled_d;
      sync_q      <= sync_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (Start || Continuous) state_d = MUX_SETTLE;
      MUX_SETTLE: if (tmr_q == '0) state_d = TRIAL;
      TRIAL:      if (tmr_q == '0) state_d = DECIDE;
      DECIDE:     state_d = (bit_q == '0) ? DONE : TRIAL;
      DONE:       state_d = (chan_q != LAST_CHAN || Continuous) ? MUX_SETTLE : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    sync_d      = {sync_q[0], gtRef};
    tmr_d       = (tmr_q != '0) ? tmr_q - TMR_W'(1) : '0;
    chan_d      = chan_q;
    bit_d       = bit_q;
    result_d    = result_q;
    adc_d       = adc_q;
    sampled_d   = 1'b0;
    samp_chan_d = samp_chan_q;
    case (state_q)
      IDLE: chan_d = '0;
      DECIDE: begin
        if (sync_q[1]) result_d[bit_q] = 1'b1;
        if (bit_q != '0) bit_d = bit_q - BW'(1);
      end
      DONE: begin
        adc_d[int'(chan_q)*WIDTH +: WIDTH] = result_q;
        sampled_d   = 1'b1;
        samp_chan_d = chan_q;
        chan_d      = (chan_q == LAST_CHAN) ? '0 : chan_q + CW'(1);
      end
      default: ;
    endcase
    // Timers are loaded on state entry and count down to a terminal zero.
    if (state_d == MUX_SETTLE && state_q != MUX_SETTLE) begin
      tmr_d    = TMR_W'(MUX_WAIT - 1);
      result_d = '0;
      bit_d    = BW'(WIDTH - 1);
    end
    if (state_d == TRIAL && state_q != TRIAL) tmr_d = TMR_W'(TRIAL_LEN - 1);
  end

  always_comb begin
    busy   = (state_q != IDLE);
    pwm_en = (state_q == TRIAL);
    trial  = result_q | (WIDTH'(1) << bit_q);
  end

  pwm_dac #(.WIDTH(WIDTH)) u_pwm_dac (
    .CLK    (CLK),
    .Reset  (Reset),
    .enable (pwm_en),
    .duty   (trial),
    .DACout (DACout)
  );

  assign ADCout      = adc_q;
  assign ADCsampled  = sampled_q;
  assign SampledChan = samp_chan_q;
  assign ChanSel     = chan_q;
  assign Busy        = busy;
endmodule

// File: tb/tb_sar_adc_multi.sv
// tb_sar_adc_multi: directed vector bench with a behavioural comparator that integrates DACout highs.
module tb_sar_adc_multi;
  localparam int W   = 4;
  localparam int CH  = 2;
  localparam int LAT = 71;

  logic          CLK = 1'b0;
  logic          Reset = 1'b0;
  logic          gtRef = 1'b0;
  logic          Start = 1'b0;
  logic          Continuous = 1'b0;
  logic [CH*W-1:0] ADCout;
  logic          ADCsampled;
  logic [0:0]    SampledChan, ChanSel;
  logic          DACout, Busy;

  int checks = 0;
  int errors = 0;
  int gt_mode = 0;  // 0 model, 1 tied high, 2 tied low
  int tgt0 = 0, tgt1 = 0;
  int run_len = 0;
  logic dac_prev = 1'b0;
  int pulses[$];
  int idle_hi = 0;

  typedef struct {
    int         mode;
    int         t0;
    int         t1;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[5];

  always #5 CLK = ~CLK;

  sar_adc_multi #(.WIDTH(W), .CHANNELS(CH), .SETTLE_PERIODS(1), .MUX_WAIT(2)) dut (
    .CLK(CLK), .Reset(Reset), .gtRef(gtRef), .Start(Start), .Continuous(Continuous),
    .ADCout(ADCout), .ADCsampled(ADCsampled), .SampledChan(SampledChan),
    .ChanSel(ChanSel), .DACout(DACout), .Busy(Busy)
  );

  // Comparator: high-count of the current DAC pulse stands in for the filtered DAC level.
  initial begin
    forever begin
      @(negedge CLK);
      if (DACout && !dac_prev) run_len = 1;
      else if (DACout) run_len++;
      if (!DACout && dac_prev) pulses.push_back(run_len);
      dac_prev = DACout;
      if (DACout && !Busy) idle_hi++;
      case (gt_mode)
        1:       gtRef = 1'b1;
        2:       gtRef = 1'b0;
        default: gtRef = (run_len <= ((ChanSel == 1'b0) ? tgt0 : tgt1));
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_start();
    @(posedge CLK); #1 Start = 1'b1;
    @(posedge CLK); #1 Start = 1'b0;
  endtask

  task automatic wait_pulse(input int max, output int n, output int cs_before);
    int last_cs;
    last_cs = int'(ChanSel);
    n = -1;
    cs_before = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (ADCsampled) begin
        n = i;
        cs_before = last_cs;
        break;
      end
      last_cs = int'(ChanSel);
    end
  endtask

  task automatic count_pulses(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (ADCsampled) cnt++;
    end
  endtask

  initial begin
    int n, n1, n2, csb, c1, c2, cnt;
    logic [7:0] prev;

    vecs[0] = '{1, 0, 0, 8'hFF};
    vecs[1] = '{0, 9, 3, 8'h39};
    vecs[2] = '{0, 15, 0, 8'h0F};
    vecs[3] = '{0, 0, 15, 8'hF0};
    vecs[4] = '{0, 10, 5, 8'h5A};

    // Reset held low for five clocks
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    chk("rst_adcout", int'(ADCout), 0);
    chk("rst_sampled", int'(ADCsampled), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_dacout", int'(DACout), 0);
    chk("rst_chansel", int'(ChanSel), 0);
    chk("rst_sampchan", int'(SampledChan), 0);
    @(posedge CLK); #1 Reset = 1'b1;
    count_pulses(20, cnt);
    chk("idle_no_pulse", cnt, 0);
    chk("idle_busy", int'(Busy), 0);

    // Single-shot vectors
    prev = 8'h00;
    for (int v = 0; v < 5; v++) begin
      gt_mode = vecs[v].mode;
      tgt0 = vecs[v].t0;
      tgt1 = vecs[v].t1;
      do_start();
      wait_pulse(200, n, csb);
      chk($sformatf("v%0d_lat0", v), n, LAT);
      chk($sformatf("v%0d_chan0", v), int'(SampledChan), 0);
      chk($sformatf("v%0d_chansel_pre", v), csb, 0);
      chk($sformatf("v%0d_chansel_post", v), int'(ChanSel), 1);
      chk($sformatf("v%0d_slice0", v), int'(ADCout[3:0]), int'(vecs[v].exp[3:0]));
      chk($sformatf("v%0d_slice1_hold", v), int'(ADCout[7:4]), int'(prev[7:4]));
      chk($sformatf("v%0d_busy_mid", v), int'(Busy), 1);
      wait_pulse(200, n, csb);
      chk($sformatf("v%0d_lat1", v), n, LAT);
      chk($sformatf("v%0d_chan1", v), int'(SampledChan), 1);
      chk($sformatf("v%0d_adcout", v), int'(ADCout), int'(vecs[v].exp));
      chk($sformatf("v%0d_busy_end", v), int'(Busy), 0);
      @(negedge CLK);
      chk($sformatf("v%0d_pulse_width", v), int'(ADCsampled), 0);
      prev = vecs[v].exp;
    end

    // Continuous scanning, ch0 target moves between scans
    gt_mode = 0; tgt0 = 5; tgt1 = 7;
    @(posedge CLK); #1 Continuous = 1'b1;
    @(posedge CLK); #1;
    wait_pulse(200, n, csb);
    chk("cont_lat0", n, LAT);
    chk("cont_chan_a", int'(SampledChan), 0);
    chk("cont_slice0_a", int'(ADCout[3:0]), 5);
    tgt0 = 12;
    wait_pulse(200, n, csb);
    chk("cont_lat1", n, LAT);
    chk("cont_chan_b", int'(SampledChan), 1);
    chk("cont_slice1_b", int'(ADCout[7:4]), 7);
    wait_pulse(200, n, csb);
    chk("cont_lat2", n, LAT);
    chk("cont_chan_c", int'(SampledChan), 0);
    chk("cont_slice0_c", int'(ADCout[3:0]), 12);
    chk("cont_slice1_c", int'(ADCout[7:4]), 7);
    repeat (30) @(posedge CLK);
    #1 Continuous = 1'b0;
    wait_pulse(200, n, csb);
    chk("cont_lat3", n, LAT - 30);
    chk("cont_chan_d", int'(SampledChan), 1);
    chk("cont_adcout", int'(ADCout), 8'h7C);
    chk("cont_busy_end", int'(Busy), 0);
    count_pulses(100, cnt);
    chk("cont_stopped", cnt, 0);

    // Reset during the bit-2 trial
    tgt0 = 6; tgt1 = 10;
    do_start();
    repeat (25) @(posedge CLK);
    #1;
    chk("abort_busy_before", int'(Busy), 1);
    Reset = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_adcout", int'(ADCout), 0);
    chk("abort_dacout", int'(DACout), 0);
    chk("abort_chansel", int'(ChanSel), 0);
    chk("abort_sampled", int'(ADCsampled), 0);
    @(posedge CLK); #1 Reset = 1'b1;
    do_start();
    wait_pulse(200, n, csb);
    chk("rerun_lat0", n, LAT);
    wait_pulse(200, n, csb);
    chk("rerun_lat1", n, LAT);
    chk("rerun_adcout", int'(ADCout), 8'hA6);

    // Start while busy is ignored; comparator tied low
    gt_mode = 2;
    pulses.delete();
    do_start();
    fork
      begin
        wait_pulse(200, n1, c1);
        wait_pulse(200, n2, c2);
      end
      begin
        repeat (30) @(posedge CLK);
        #1 Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
      end
    join
    chk("busy_start_lat0", n1, LAT);
    chk("busy_start_lat1", n2, LAT);
    chk("zero_adcout", int'(ADCout), 0);
    chk("zero_busy_end", int'(Busy), 0);
    count_pulses(80, cnt);
    chk("busy_start_no_extra", cnt, 0);
    chk("dac_pulse_count", pulses.size(), 8);
    for (int i = 0; i < pulses.size() && i < 8; i++)
      chk($sformatf("dac_pulse_%0d", i), pulses[i], 8 >> (i % 4));
    chk("dac_idle_high", idle_hi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
